// File: rtl/eth_pkg.sv
// Shared constants, state encoding and FCS byte ordering for the byte-wide
// Ethernet transmit path.
package eth_pkg;

  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD           = 8'hD5;
  localparam logic [7:0] ETH_PAD_BYTE      = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    IFG
  } eth_tx_state_e;

  // Byte k of the FCS: complemented CRC, bit i = ~crc[31-8k-i], so the first
  // bit on the wire is the complement of crc[31].
  function automatic logic [7:0] eth_fcs_byte(input logic [31:0] crc, input logic [1:0] k);
    logic [31:0] s;
    logic [7:0]  b;
    s = crc << {k, 3'b000};
    for (int i = 0; i < 8; i++) begin
      b[i] = ~s[31-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/iob_eth_tx_framer.sv
// Byte-wide Ethernet transmit framer: preamble/SFD, payload, zero pad, FCS
// from the neighbouring CRC-32 stage, then the inter-frame gap.
module iob_eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD    = 60,
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic        tx_er,
  output logic [7:0]  tx_data,
  output logic        crc_start,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  input  logic [31:0] crc_in
);

  localparam int               CNT_W = 16;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PAYLOAD);
  localparam logic [CNT_W-1:0] IFG_C = CNT_W'(IFG_BYTES);
  localparam logic [CNT_W-1:0] PRE_C = CNT_W'(PREAMBLE_BYTES);

  eth_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] paycnt_q, paycnt_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [CNT_W:0]   pay_inc;
  logic             pay_done;
  logic [CNT_W-1:0] cnt_inc;

  assign pay_inc  = {1'b0, paycnt_q} + (CNT_W+1)'(1);
  assign pay_done = pay_inc >= {1'b0, MIN_C};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paycnt_d  = paycnt_q;
    tx_en_d   = tx_en_q;
    tx_er_d   = tx_er_q;
    tx_data_d = tx_data_q;
    if (tx_ready) begin
      case (state_q)
        IDLE: begin
          tx_en_d = 1'b0;
          tx_er_d = 1'b0;
          if (in_valid) begin
            tx_data_d = ETH_PREAMBLE_BYTE;
            tx_en_d   = 1'b1;
            cnt_d     = CNT_W'(1);
            paycnt_d  = '0;
            state_d   = PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (cnt_q < PRE_C) begin
            tx_data_d = ETH_PREAMBLE_BYTE;
            cnt_d     = cnt_inc;
          end else begin
            tx_data_d = ETH_SFD;
            cnt_d     = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          if (in_valid) begin
            tx_data_d = in_data;
            paycnt_d  = (paycnt_q < MIN_C) ? pay_inc[CNT_W-1:0] : paycnt_q;
            if (in_last) begin
              cnt_d   = '0;
              state_d = pay_done ? FCS : PAD;
            end
          end else begin
            // Underrun: flag the beat as an error and abandon the frame.
            tx_er_d = 1'b1;
            cnt_d   = '0;
            state_d = IFG;
          end
        end
        PAD: begin
          tx_data_d = ETH_PAD_BYTE;
          paycnt_d  = pay_inc[CNT_W-1:0];
          if (pay_done) begin
            cnt_d   = '0;
            state_d = FCS;
          end
        end
        FCS: begin
          tx_data_d = eth_fcs_byte(crc_in, cnt_q[1:0]);
          cnt_d     = cnt_inc;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = '0;
            state_d = IFG;
          end
        end
        IFG: begin
          tx_en_d   = 1'b0;
          tx_er_d   = 1'b0;
          tx_data_d = 8'h00;
          cnt_d     = cnt_inc;
          if (cnt_inc >= IFG_C) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paycnt_q  <= '0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paycnt_q  <= paycnt_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_er   = tx_er_q;
  assign tx_data = tx_data_q;

  // CRC controls are combinational so the CRC stage advances on the same edge
  // that loads the byte into tx_data; crc_in is then current for the FCS beats.
  assign in_ready  = (state_q == DATA) && tx_ready;
  assign crc_en    = tx_ready && (((state_q == DATA) && in_valid) || (state_q == PAD));
  assign crc_data  = (state_q == DATA) ? in_data : ETH_PAD_BYTE;
  assign crc_start = (state_q == IDLE) || (state_q == PREAMBLE) || (state_q == IFG);

endmodule
